instr_encoder_loader: RTL and testbench

//  Inverse of the RV32I control decoder: takes decoded instruction fields (type class, operator,
//  rd/rs1/rs2, immediate) over a valid/ready stream and packs them into 32-bit RV32I instruction words.

---
 rtl/instr_encoder_loader.sv | 144 ++++++++++++++
 tb/tb_instr_encoder_loader.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// Packs decoded RV32I field bundles into instruction words and streams
// them to instruction memory at an auto-incrementing word address.
module instr_encoder_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_type,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       out_instr,
    output logic              err_illegal,
    output logic              wrapped,
    output logic [ADDR_W:0]   word_cnt
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_instr_q, out_instr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic              wrap_q, wrap_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;

    logic [31:0] enc;
    logic        legal;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        is_shift;
    logic        accept;
    logic        retire;

    assign f3       = in_op[2:0];
    assign f7       = in_op[3] ? 7'h20 : 7'h00;
    assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);
    assign in_ready = !start && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign retire   = out_valid_q && out_ready;

    always_comb begin
        enc   = 32'h0;
        legal = 1'b1;
        case (in_type)
            4'd0: enc = {f7, in_rs2, in_rs1, f3, in_rd, 7'b0110011};
            4'd1: begin
                if (is_shift) begin
                    legal = (in_imm[31:5] == 27'h0);
                    enc = {1'b0, in_op[3], 5'b0, in_imm[4:0],
                           in_rs1, f3, in_rd, 7'b0010011};
                end else begin
                    enc = {in_imm[11:0], in_rs1, f3, in_rd, 7'b0010011};
                end
            end
            4'd2: begin
                legal = !(f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
                enc = {in_imm[11:0], in_rs1, f3, in_rd, 7'b0000011};
            end
            4'd3: enc = {in_imm[11:5], in_rs2, in_rs1, f3,
                         in_imm[4:0], 7'b0100011};
            4'd4: begin
                legal = !in_imm[0];
                enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3,
                       in_imm[4:1], in_imm[11], 7'b1100011};
            end
            4'd5: enc = {in_imm[31:12], in_rd, 7'b0110111};
            4'd6: enc = {in_imm[31:12], in_rd, 7'b0010111};
            4'd7: begin
                legal = !in_imm[0];
                enc = {in_imm[20], in_imm[10:1], in_imm[11],
                       in_imm[19:12], in_rd, 7'b1101111};
            end
            4'd8: enc = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b1100111};
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        addr_d      = addr_q;
        err_d       = err_q;
        wrap_d      = wrap_q;
        cnt_d       = cnt_q;
        if (retire) begin
            out_valid_d = 1'b0;
            addr_d      = addr_q + 1'b1;
            if (addr_q == {ADDR_W{1'b1}}) wrap_d = 1'b1;
            if (cnt_q != {(ADDR_W+1){1'b1}}) cnt_d = cnt_q + 1'b1;
        end
        if (accept) begin
            if (legal) begin
                out_valid_d = 1'b1;
                out_instr_d = enc;
            end else begin
                err_d = 1'b1;
            end
        end
        // start discards any pending word and rewinds the loader
        if (start) begin
            out_valid_d = 1'b0;
            addr_d      = BASE;
            err_d       = 1'b0;
            wrap_d      = 1'b0;
            cnt_d       = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_instr_q <= 32'h0;
            addr_q      <= BASE;
            err_q       <= 1'b0;
            wrap_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            addr_q      <= addr_d;
            err_q       <= err_d;
            wrap_q      <= wrap_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_instr   = out_instr_q;
    assign out_addr    = addr_q;
    assign err_illegal = err_q;
    assign wrapped     = wrap_q;
    assign word_cnt    = cnt_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader with a small address space
// so wrap and counter saturation are reached quickly.
module tb_instr_encoder_loader;

    localparam int AW = 2;
    localparam int NW = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    in_type = '0;
    logic [3:0]    in_op = '0;
    logic [4:0]    in_rd = '0;
    logic [4:0]    in_rs1 = '0;
    logic [4:0]    in_rs2 = '0;
    logic [31:0]   in_imm = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [AW-1:0] out_addr;
    logic [31:0]   out_instr;
    logic          err_illegal;
    logic          wrapped;
    logic [AW:0]   word_cnt;

    instr_encoder_loader #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_type(in_type), .in_op(in_op), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_instr(out_instr),
        .err_illegal(err_illegal), .wrapped(wrapped),
        .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          addr;
        logic [31:0] instr;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_cnt = 0;
    bit   m_err = 0;
    bit   rdy_rand = 0;
    bit   rdy_fix = 1;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_enc(
        input logic [3:0] t, input logic [3:0] op,
        input logic [4:0] rd, input logic [4:0] rs1,
        input logic [4:0] rs2, input logic [31:0] imm,
        output bit ok);
        logic [31:0] f3, f7, i12, r;
        f3 = 32'(op) % 8;
        f7 = (op >= 8) ? 32 : 0;
        ok = 1;
        r  = 0;
        case (int'(t))
            0: r = (f7 << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
                 | (f3 << 12) | (32'(rd) << 7) | 32'h33;
            1: begin
                if (f3 == 1 || f3 == 5) begin
                    ok  = (imm < 32);
                    i12 = (imm % 32) + ((op >= 8) ? 1024 : 0);
                end else begin
                    i12 = imm % 4096;
                end
                r = (i12 << 20) | (32'(rs1) << 15) | (f3 << 12)
                  | (32'(rd) << 7) | 32'h13;
            end
            2: begin
                ok = !(f3 == 3 || f3 == 6 || f3 == 7);
                r = ((imm % 4096) << 20) | (32'(rs1) << 15) | (f3 << 12)
                  | (32'(rd) << 7) | 32'h03;
            end
            3: r = (((imm / 32) % 128) << 25) | (32'(rs2) << 20)
                 | (32'(rs1) << 15) | (f3 << 12) | ((imm % 32) << 7)
                 | 32'h23;
            4: begin
                ok = (imm % 2 == 0);
                r = (((imm / 4096) % 2) << 31) | (((imm / 32) % 64) << 25)
                  | (32'(rs2) << 20) | (32'(rs1) << 15) | (f3 << 12)
                  | (((imm / 2) % 16) << 8) | (((imm / 2048) % 2) << 7)
                  | 32'h63;
            end
            5: r = (imm / 4096) * 4096 + (32'(rd) << 7) + 32'h37;
            6: r = (imm / 4096) * 4096 + (32'(rd) << 7) + 32'h17;
            7: begin
                ok = (imm % 2 == 0);
                r = (((imm / 1048576) % 2) << 31) | (((imm / 2) % 1024) << 21)
                  | (((imm / 2048) % 2) << 20) | (((imm / 4096) % 256) << 12)
                  | (32'(rd) << 7) | 32'h6F;
            end
            8: r = ((imm % 4096) << 20) | (32'(rs1) << 15)
                 | (32'(rd) << 7) | 32'h67;
            default: ok = 0;
        endcase
        return r;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #2;
            out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
        end
    end

    bit          stall_prev = 0;
    logic [31:0] held_instr;
    logic [AW-1:0] held_addr;

    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_instr", 64'(out_instr), 64'(held_instr));
                check("hold_addr", 64'(out_addr), 64'(held_addr));
            end
            if (start) check("start_ready", 64'(in_ready), 64'd0);
            if (out_valid && !out_ready)
                check("stall_ready", 64'(in_ready), 64'd0);
            if (out_valid && out_ready && !start) begin
                if (q.size() == 0) begin
                    check("spurious_write", 64'(out_instr), 64'hDEAD);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("wr_addr", 64'(out_addr), 64'(e.addr));
                    check("wr_instr", 64'(out_instr), 64'(e.instr));
                end
            end
            stall_prev = out_valid && !out_ready && !start;
            held_instr = out_instr;
            held_addr  = out_addr;
        end
    end

    task automatic send(input logic [3:0] t, input logic [3:0] op,
                        input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm,
                        input bit lg, input logic [31:0] ins);
        bit hs = 0;
        in_valid = 1; in_type = t; in_op = op;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            if (hs) break;
        end
        if (!hs) check("accept_timeout", 64'd0, 64'd1);
        else if (lg) begin
            exp_t e;
            e.addr  = m_cnt % NW;
            e.instr = ins;
            q.push_back(e);
            m_cnt++;
        end else begin
            m_err = 1;
        end
        #1 in_valid = 0;
    endtask

    task automatic send_ref(input logic [3:0] t, input logic [3:0] op,
                            input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [31:0] imm);
        bit ok;
        logic [31:0] ins;
        ins = ref_enc(t, op, rd, rs1, rs2, imm, ok);
        send(t, op, rd, rs1, rs2, imm, ok, ins);
    endtask

    task automatic directed(input logic [3:0] t, input logic [3:0] op,
                            input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [31:0] imm,
                            input logic [31:0] ins);
        send(t, op, rd, rs1, rs2, imm, 1, ins);
        @(negedge clk);
        check("latency_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        bit done = 0;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (q.size() == 0 && !out_valid) begin
                done = 1;
                break;
            end
        end
        if (!done) check("drain_timeout", 64'(q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic rand_word();
        logic [3:0] t;
        logic [31:0] imm;
        t = 4'($urandom_range(0, 10));
        case ($urandom_range(0, 3))
            0: imm = $urandom;
            1: imm = 32'($urandom_range(0, 31));
            2: imm = 32'($urandom_range(0, 255)) * 2;
            default: imm = 32'(-$signed(32'($urandom_range(1, 100))) * 2);
        endcase
        send_ref(t, 4'($urandom), 5'($urandom), 5'($urandom),
                 5'($urandom), imm);
    endtask

    initial begin
        #12;
        @(negedge clk);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_instr", 64'(out_instr), 64'd0);
        check("rst_addr", 64'(out_addr), 64'd0);
        check("rst_err", 64'(err_illegal), 64'd0);
        check("rst_wrap", 64'(wrapped), 64'd0);
        check("rst_cnt", 64'(word_cnt), 64'd0);
        @(posedge clk); #1 reset = 0;
        @(posedge clk); #1;

        directed(4'd0, 4'b0000, 5'd3, 5'd1, 5'd2, 32'd0, 32'h002081B3);
        directed(4'd0, 4'b1000, 5'd3, 5'd1, 5'd2, 32'd0, 32'h402081B3);
        directed(4'd1, 4'b1101, 5'd5, 5'd6, 5'd0, 32'd3, 32'h40335293);
        directed(4'd4, 4'b0000, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC,
                 32'hFE208EE3);
        send(4'd4, 4'b0000, 5'd0, 5'd1, 5'd2, 32'd3, 0, 32'h0);
        @(negedge clk);
        check("illegal_err", 64'(err_illegal), 64'd1);
        @(posedge clk); #1;
        directed(4'd7, 4'b0000, 5'd1, 5'd0, 5'd0, 32'd8, 32'h008000EF);
        directed(4'd8, 4'b0000, 5'd0, 5'd1, 5'd0, 32'd0, 32'h00008067);
        drain();
        check("dir_wrapped", 64'(wrapped), 64'd1);
        check("dir_cnt", 64'(word_cnt), 64'd6);
        check("dir_addr", 64'(out_addr), 64'd2);
        check("dir_err", 64'(err_illegal), 64'd1);

        fork
            begin
                for (int i = 0; i < 6; i++)
                    send_ref(4'd0, 4'($urandom), 5'($urandom),
                             5'($urandom), 5'($urandom), 32'd0);
            end
            begin
                repeat (3) @(posedge clk);
                rdy_fix = 0;
                repeat (3) @(posedge clk);
                rdy_fix = 1;
            end
        join
        drain();
        check("sat_cnt", 64'(word_cnt), 64'd7);

        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        m_cnt = 0; m_err = 0;
        @(negedge clk);
        check("start_addr", 64'(out_addr), 64'd0);
        check("start_err", 64'(err_illegal), 64'd0);
        check("start_wrap", 64'(wrapped), 64'd0);
        check("start_cnt", 64'(word_cnt), 64'd0);
        @(posedge clk); #1;

        rdy_rand = 1;
        for (int i = 0; i < 60; i++) rand_word();
        drain();
        rdy_rand = 0;
        rdy_fix = 1;
        @(negedge clk);
        check("rnd_cnt", 64'(word_cnt), 64'((m_cnt > 7) ? 7 : m_cnt));
        check("rnd_wrap", 64'(wrapped), 64'(m_cnt >= NW));
        check("rnd_err", 64'(err_illegal), 64'(m_err));
        check("rnd_addr", 64'(out_addr), 64'(m_cnt % NW));
        @(posedge clk); #1;

        rdy_fix = 0;
        @(posedge clk); #1;
        send_ref(4'd5, 4'd0, 5'd7, 5'd0, 5'd0, 32'h12345000);
        #2 reset = 1;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_addr", 64'(out_addr), 64'd0);
        check("mid_rst_cnt", 64'(word_cnt), 64'd0);
        q.delete();
        m_cnt = 0; m_err = 0;
        @(negedge clk);
        @(posedge clk); #1 reset = 0;
        rdy_fix = 1;
        @(posedge clk); #1;
        send_ref(4'd6, 4'd0, 5'd9, 5'd0, 5'd0, 32'hABCDE123);
        drain();
        check("post_rst_cnt", 64'(word_cnt), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
